// File: rtl/pc_unit_pipe_if.sv
// Bundle between the IF-stage PC unit and its control/hazard logic.
// The master drives the selection controls, and the slave (the PC unit) returns the fetch state.
interface pc_unit_pipe_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic [2:0]        PCSrc;
    logic              ALUOut0;
    logic [ADDR_W-1:0] ConBA;
    logic [ADDR_W-1:0] DatabusA;
    logic [25:0]       JT;
    logic              irq;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] PC_plus4;
    logic [ADDR_W-1:0] EPC;
    logic              kernel;
    logic              redirect;

    modport master (
        output stall, PCSrc, ALUOut0, ConBA, DatabusA, JT, irq,
        input  PC, PC_plus4, EPC, kernel, redirect
    );

    modport slave (
        input  stall, PCSrc, ALUOut0, ConBA, DatabusA, JT, irq,
        output PC, PC_plus4, EPC, kernel, redirect
    );
endinterface

// File: rtl/pc_unit_pipe.sv
// Pipelined IF-stage PC unit: next-PC selection, stall hold, latched interrupt,
// EPC capture, kernel-bit protection and a one-cycle redirect/flush pulse.
module pc_unit_pipe #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic           clk,
    input  logic           reset,
    pc_unit_pipe_if.slave  bus
);
    localparam logic [ADDR_W-1:0] RST_PC    = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ILLOP_PC  = ILLOP_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] XADR_PC   = XADR_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-2:0] LOW_FOUR  = (ADDR_W-1)'(4);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              redirect_q, redirect_d;
    logic              irq_pend_q, irq_pend_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] cand;
    logic              k;
    logic              seq_pick;
    logic              trap_src;
    logic              take_irq;
    logic              unused_conba_msb;

    assign k                = pc_q[ADDR_W-1];
    assign pc_plus4         = {k, pc_q[ADDR_W-2:0] + LOW_FOUR};
    assign trap_src         = bus.PCSrc[2];
    assign take_irq         = (irq_pend_q | bus.irq) & ~k & ~trap_src;
    assign unused_conba_msb = bus.ConBA[ADDR_W-1];

    // Candidate address; jr can only clear the kernel bit, never set it.
    always_comb begin
        cand     = pc_plus4;
        seq_pick = 1'b1;
        case (bus.PCSrc)
            3'b000: begin
                cand     = pc_plus4;
                seq_pick = 1'b1;
            end
            3'b001: begin
                if (bus.ALUOut0) begin
                    cand     = {k, bus.ConBA[ADDR_W-2:0]};
                    seq_pick = 1'b0;
                end
            end
            3'b010: begin
                cand     = {pc_plus4[ADDR_W-1:28], bus.JT, 2'b00};
                seq_pick = 1'b0;
            end
            3'b011: begin
                cand     = {k & bus.DatabusA[ADDR_W-1], bus.DatabusA[ADDR_W-2:0]};
                seq_pick = 1'b0;
            end
            3'b100: begin
                cand     = ILLOP_PC;
                seq_pick = 1'b0;
            end
            default: begin
                cand     = XADR_PC;
                seq_pick = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        irq_pend_d = irq_pend_q | bus.irq;
        if (!bus.stall) begin
            if (trap_src) begin
                pc_d       = cand;
                epc_d      = (bus.PCSrc == 3'b100) ? pc_plus4 : pc_q;
                redirect_d = 1'b1;
            end else if (take_irq) begin
                pc_d       = ILLOP_PC;
                epc_d      = cand;
                irq_pend_d = 1'b0;
                redirect_d = 1'b1;
            end else begin
                pc_d       = cand;
                redirect_d = ~seq_pick;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RST_PC;
            epc_q      <= '0;
            redirect_q <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_plus4 = pc_plus4;
    assign bus.EPC      = epc_q;
    assign bus.kernel   = k;
    assign bus.redirect = redirect_q;
endmodule

// File: tb/tb_pc_unit_pipe.sv
// Scoreboard bench for pc_unit_pipe: a 32-bit instance for the main scenarios and
// a 30-bit instance (kernel reset vector 0x2000_0000) for the narrow-width checks.
module tb_pc_unit_pipe;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        red;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    exp_t qm[$];
    exp_t q30[$];
    exp_t em;
    exp_t e30;

    pc_unit_pipe_if #(.ADDR_W(32)) bm ();
    pc_unit_pipe_if #(.ADDR_W(30)) b30 ();

    pc_unit_pipe #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bm)
    );

    pc_unit_pipe #(.ADDR_W(30), .RESET_VEC(32'h2000_0000)) dut30 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b30)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", nm, got, want);
    endtask

    always @(posedge clk) begin
        #1;
        if (qm.size() > 0) begin
            em = qm.pop_front();
            chk("pc",       bm.PC, em.pc);
            chk("epc",      bm.EPC, em.epc);
            chk("redirect", {31'b0, bm.redirect}, {31'b0, em.red});
            chk("kernel",   {31'b0, bm.kernel}, {31'b0, em.pc[31]});
            chk("pc_plus4", bm.PC_plus4, {em.pc[31], em.pc[30:0] + 31'd4});
        end
    end

    always @(posedge clk) begin
        #1;
        if (q30.size() > 0) begin
            e30 = q30.pop_front();
            chk("pc30",       {2'b0, b30.PC}, e30.pc);
            chk("epc30",      {2'b0, b30.EPC}, e30.epc);
            chk("redirect30", {31'b0, b30.redirect}, {31'b0, e30.red});
            chk("kernel30",   {31'b0, b30.kernel}, {31'b0, e30.pc[29]});
            chk("pc_plus4_30", {2'b0, b30.PC_plus4}, {2'b0, e30.pc[29], e30.pc[28:0] + 29'd4});
        end
    end

    // Drive one edge on the 32-bit instance and queue the expected post-edge state.
    task automatic t(input logic [2:0] src, input logic [31:0] opnd, input logic alu,
                     input logic i, input logic st,
                     input logic [31:0] epc_pc, input logic [31:0] e_epc, input logic e_red);
        exp_t e;
        bm.PCSrc    = src;
        bm.ConBA    = opnd;
        bm.DatabusA = opnd;
        bm.JT       = opnd[25:0];
        bm.ALUOut0  = alu;
        bm.irq      = i;
        bm.stall    = st;
        e.pc = epc_pc; e.epc = e_epc; e.red = e_red;
        qm.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic t30(input logic [2:0] src, input logic [31:0] opnd,
                       input logic [31:0] e_pc, input logic [31:0] e_epc, input logic e_red);
        exp_t e;
        b30.PCSrc    = src;
        b30.ConBA    = opnd[29:0];
        b30.DatabusA = opnd[29:0];
        b30.JT       = opnd[25:0];
        b30.ALUOut0  = 1'b0;
        b30.irq      = 1'b0;
        b30.stall    = 1'b0;
        e.pc = e_pc; e.epc = e_epc; e.red = e_red;
        q30.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        b30.stall = 1'b1; b30.PCSrc = 3'b000; b30.ALUOut0 = 1'b0; b30.ConBA = '0;
        b30.DatabusA = '0; b30.JT = '0; b30.irq = 1'b0;

        // Reset then sequential fetch
        rst_n = 1'b0;
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
        rst_n = 1'b1;
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0, 1'b0);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 1'b0);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_000C, 32'h0, 1'b0);
        rst_n = 1'b0;
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
        rst_n = 1'b1;

        // Branch taken / not taken, jump, jr kernel->user
        t(3'b001, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'h8000_0080, 32'h0, 1'b1);
        t(3'b001, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 32'h8000_0084, 32'h0, 1'b0);
        t(3'b010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h8000_0080, 32'h0, 1'b1);
        t(3'b011, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 1'b1);

        // User jr cannot set kernel bit; low-field wrap
        t(3'b011, 32'h8000_1000, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 1'b1);
        t(3'b011, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);

        // Interrupt arrives during stall, taken on first free edge
        t(3'b011, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0000_0104, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h0000_0104, 1'b0);
        t(3'b011, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0104, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0204, 32'h0000_0104, 1'b0);

        // Interrupt PCSrc, then irq in kernel deferred until after return to user
        t(3'b100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0000_0208, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0000_0208, 1'b0);
        t(3'b011, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0208, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0000_0304, 1'b1);

        // Exception beats simultaneous irq; irq stays pending
        t(3'b011, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0304, 1'b1);
        t(3'b101, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0000_0200, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_000C, 32'h0000_0200, 1'b0);
        t(3'b011, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0200, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0000_0504, 1'b1);

        // Reserved code acts as exception; taken branch onto PC+4 still redirects
        t(3'b110, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h8000_0004, 1'b1);
        t(3'b001, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'h8000_000C, 32'h8000_0004, 1'b1);

        // Reset wins over stall and clears the pending irq
        rst_n = 1'b0;
        t(3'b000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
        rst_n = 1'b1;
        t(3'b011, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 1'b1);
        t(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0604, 32'h0, 1'b0);

        // 30-bit instance: sequential, jr to user, wrap, jump
        rst_n = 1'b0;
        t30(3'b000, 32'h0, 32'h2000_0000, 32'h0, 1'b0);
        rst_n = 1'b1;
        t30(3'b000, 32'h0, 32'h2000_0004, 32'h0, 1'b0);
        t30(3'b000, 32'h0, 32'h2000_0008, 32'h0, 1'b0);
        t30(3'b000, 32'h0, 32'h2000_000C, 32'h0, 1'b0);
        t30(3'b011, 32'h1FFF_FFFC, 32'h1FFF_FFFC, 32'h0, 1'b1);
        t30(3'b000, 32'h0, 32'h0000_0000, 32'h0, 1'b0);
        t30(3'b010, 32'h03FF_FFFF, 32'h0FFF_FFFC, 32'h0, 1'b1);

        #2;
        chk("queues_drained", qm.size() + q30.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
